// File: rtl/scoreboard_mp_if.sv
// scoreboard_mp_if: issue/writeback/read bundle of the multi-port register scoreboard.
//   master modport : issue logic side (drives issue, read-port and writeback requests)
//   slave modport  : scoreboard side (returns tags, readiness and issue permission)
// Signals:
//   flush_i        pipeline invalidate request
//   issue_ready_o  new bundle may issue
//   is_valid_i     per-lane issue valid
//   is_w_addr_i    per-lane destination register
//   is_w_tag_o     per-lane allocated tag
//   is_r_addr_i    per-read-port source register
//   is_r_tag_o     per-read-port producer tag
//   is_r_ready_o   per-read-port source committed
//   wb_valid_i     per-lane writeback valid
//   wb_w_addr_i    per-lane writeback register
//   wb_w_tag_i     per-lane writeback tag
interface scoreboard_mp_if #(
  parameter int unsigned ISSUE_W     = 2,
  parameter int unsigned RP_PER_LANE = 2,
  parameter int unsigned SEQ_W       = 3
);
  localparam int unsigned RP     = ISSUE_W * RP_PER_LANE;
  localparam int unsigned LANE_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int unsigned TAG_W  = SEQ_W + LANE_W;

  logic                           flush_i;
  logic                           issue_ready_o;
  logic [ISSUE_W-1:0]             is_valid_i;
  logic [ISSUE_W-1:0][4:0]        is_w_addr_i;
  logic [ISSUE_W-1:0][TAG_W-1:0]  is_w_tag_o;
  logic [RP-1:0][4:0]             is_r_addr_i;
  logic [RP-1:0][TAG_W-1:0]       is_r_tag_o;
  logic [RP-1:0]                  is_r_ready_o;
  logic [ISSUE_W-1:0]             wb_valid_i;
  logic [ISSUE_W-1:0][4:0]        wb_w_addr_i;
  logic [ISSUE_W-1:0][TAG_W-1:0]  wb_w_tag_i;

  modport master (
    output flush_i,
    output is_valid_i,
    output is_w_addr_i,
    output is_r_addr_i,
    output wb_valid_i,
    output wb_w_addr_i,
    output wb_w_tag_i,
    input  issue_ready_o,
    input  is_w_tag_o,
    input  is_r_tag_o,
    input  is_r_ready_o
  );

  modport slave (
    input  flush_i,
    input  is_valid_i,
    input  is_w_addr_i,
    input  is_r_addr_i,
    input  wb_valid_i,
    input  wb_w_addr_i,
    input  wb_w_tag_i,
    output issue_ready_o,
    output is_w_tag_o,
    output is_r_tag_o,
    output is_r_ready_o
  );
endinterface

// File: rtl/scoreboard_mp.sv
// scoreboard_mp: multi-lane register scoreboard.
// Each issued destination register gets a tag {seq, lane} recorded in the issue table (IT);
// writebacks record their tag in the commit table (CT). A source is ready when both tables
// hold the same tag for it. An in-flight counter throttles issue so live tags never alias,
// and a flush drains all outstanding writebacks before issue resumes.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   sb   : scoreboard_mp_if.slave bundle (issue, read ports, writeback, flush)
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let same-cycle writebacks bypass into
// the readiness comparison; otherwise readiness rises the cycle after writeback.
module scoreboard_mp #(
  parameter int unsigned ISSUE_W     = 2,
  parameter int unsigned RP_PER_LANE = 2,
  parameter int unsigned SEQ_W       = 3
) (
  input  logic           clk,
  input  logic           rst,
  scoreboard_mp_if.slave sb
);
  localparam int unsigned RP     = ISSUE_W * RP_PER_LANE;
  localparam int unsigned LANE_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int unsigned TAG_W  = SEQ_W + LANE_W;
  localparam int unsigned CNT_W  = SEQ_W + LANE_W + 1;
  // Highest in-flight count after which one more full bundle would still be alias-free.
  localparam int unsigned LIMIT  = (1 << SEQ_W) - 2;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                        state_q, state_d;
  logic [SEQ_W-1:0]              seq_q, seq_d;
  logic [CNT_W-1:0]              inflight_q, inflight_d;
  logic [31:0][TAG_W-1:0]        it_q, it_d;
  logic [31:0][TAG_W-1:0]        ct_q, ct_d;
  logic [31:0][TAG_W-1:0]        ct_rd;

  logic                          room_ok;
  logic                          issue_ready;
  logic [ISSUE_W-1:0]            acc;
  logic [ISSUE_W-1:0][TAG_W-1:0] w_tag;
  logic [CNT_W-1:0]              n_iss, n_wb;
  logic [RP-1:0][TAG_W-1:0]      r_tag;
  logic [RP-1:0]                 r_rdy;

  // Allocated tags: sequence number in the upper bits, lane index below.
  always_comb begin
    for (int l = 0; l < ISSUE_W; l++) begin
      w_tag[l] = {seq_q, LANE_W'(l)};
    end
  end

  // Gating is purely registered: a flush only blocks issue from the following cycle on.
  assign room_ok     = ({1'b0, inflight_q} + (CNT_W+1)'(ISSUE_W)) <= (CNT_W+1)'(LIMIT);
  assign issue_ready = (state_q == StIdle) && room_ok;
  assign acc         = sb.is_valid_i & {ISSUE_W{issue_ready}};

  // Table writes; ascending lane order makes the highest lane win on same-address writes.
  always_comb begin
    it_d  = it_q;
    ct_d  = ct_q;
    n_iss = '0;
    n_wb  = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      if (acc[l] && (sb.is_w_addr_i[l] != 5'd0)) begin
        it_d[sb.is_w_addr_i[l]] = w_tag[l];
        n_iss                   = n_iss + CNT_W'(1);
      end
    end
    for (int l = 0; l < ISSUE_W; l++) begin
      if (sb.wb_valid_i[l] && (sb.wb_w_addr_i[l] != 5'd0)) begin
        ct_d[sb.wb_w_addr_i[l]] = sb.wb_w_tag_i[l];
        n_wb                    = n_wb + CNT_W'(1);
      end
    end
    inflight_d = inflight_q + n_iss - n_wb;
  end

  // Sequence counter skips 0, which is reserved for "no producer pending".
  always_comb begin
    seq_d = seq_q;
    if (|acc) begin
      seq_d = (seq_q == '1) ? SEQ_W'(1) : seq_q + SEQ_W'(1);
    end
  end

  // Flush FSM: stay in drain until every outstanding writeback has returned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sb.flush_i) state_d = StDrain;
      end
      StDrain: begin
        if (!sb.flush_i && (inflight_d == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign ct_rd = ct_d;
`else
  assign ct_rd = ct_q;
`endif

  // Source reads: r0 is hardwired to tag 0 / ready.
  always_comb begin
    for (int p = 0; p < RP; p++) begin
      if (sb.is_r_addr_i[p] == 5'd0) begin
        r_tag[p] = '0;
        r_rdy[p] = 1'b1;
      end else begin
        r_tag[p] = it_q[sb.is_r_addr_i[p]];
        r_rdy[p] = (it_q[sb.is_r_addr_i[p]] == ct_rd[sb.is_r_addr_i[p]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      seq_q      <= SEQ_W'(1);
      inflight_q <= '0;
      it_q       <= '0;
      ct_q       <= '0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      inflight_q <= inflight_d;
      it_q       <= it_d;
      ct_q       <= ct_d;
    end
  end

  assign sb.issue_ready_o = issue_ready;
  assign sb.is_w_tag_o    = w_tag;
  assign sb.is_r_tag_o    = r_tag;
  assign sb.is_r_ready_o  = r_rdy;

endmodule

// File: tb/tb_scoreboard_mp.sv
// Self-checking bench for scoreboard_mp: directed vector table, hand-written corner
// sequences (throttle, sequence wrap, flush drain, reset in drain) and a randomized phase,
// all compared against a behavioural model of the issue/commit tables.
module tb_scoreboard_mp;
  localparam int unsigned ISSUE_W = 2;
  localparam int unsigned RPL     = 2;
  localparam int unsigned SEQ_W   = 3;
  localparam int unsigned RP      = ISSUE_W * RPL;
  localparam int unsigned LANE_W  = 1;
  localparam int unsigned TAG_W   = SEQ_W + LANE_W;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  scoreboard_mp_if #(.ISSUE_W(ISSUE_W), .RP_PER_LANE(RPL), .SEQ_W(SEQ_W)) bus ();

  scoreboard_mp #(.ISSUE_W(ISSUE_W), .RP_PER_LANE(RPL), .SEQ_W(SEQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus variables
  logic                 v_rst;
  logic                 v_fl;
  logic [ISSUE_W-1:0]   v_iv;
  logic [4:0]           v_wa  [ISSUE_W];
  logic [ISSUE_W-1:0]   v_wbv;
  logic [4:0]           v_wba [ISSUE_W];
  logic [TAG_W-1:0]     v_wbt [ISSUE_W];
  logic [4:0]           v_ra  [RP];

  // Reference model
  int m_it [32];
  int m_ct [32];
  int m_seq;
  int m_infl;
  bit m_drain;

  typedef struct { int a; int t; } pend_t;
  pend_t pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clear_in();
    v_rst = 1'b0;
    v_fl  = 1'b0;
    v_iv  = '0;
    v_wbv = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      v_wa[l] = 5'd0; v_wba[l] = 5'd0; v_wbt[l] = '0;
    end
    for (int p = 0; p < RP; p++) v_ra[p] = 5'd0;
  endtask

  task automatic drive();
    rst              = v_rst;
    bus.flush_i      = v_fl;
    bus.is_valid_i   = v_iv;
    bus.wb_valid_i   = v_wbv;
    for (int l = 0; l < ISSUE_W; l++) begin
      bus.is_w_addr_i[l] = v_wa[l];
      bus.wb_w_addr_i[l] = v_wba[l];
      bus.wb_w_tag_i[l]  = v_wbt[l];
    end
    for (int p = 0; p < RP; p++) bus.is_r_addr_i[p] = v_ra[p];
  endtask

  function automatic bit m_ready();
    return !m_drain && ((m_infl + int'(ISSUE_W)) <= ((1 << SEQ_W) - 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_it[i] = 0; m_ct[i] = 0; end
    m_seq = 1; m_infl = 0; m_drain = 1'b0;
    pend.delete();
  endtask

  task automatic model_check();
    int ct_v [32];
    ct_v = m_ct;
    if (BYP) begin
      for (int l = 0; l < ISSUE_W; l++)
        if (v_wbv[l] && v_wba[l] != 0) ct_v[v_wba[l]] = int'(v_wbt[l]);
    end
    chk("model issue_ready", 32'(bus.issue_ready_o), 32'(m_ready()));
    for (int l = 0; l < ISSUE_W; l++)
      chk($sformatf("model w_tag[%0d]", l), 32'(bus.is_w_tag_o[l]),
          32'(m_seq * (1 << LANE_W) + l));
    for (int p = 0; p < RP; p++) begin
      chk($sformatf("model r_tag[%0d] r%0d", p, v_ra[p]), 32'(bus.is_r_tag_o[p]),
          32'(m_it[v_ra[p]]));
      chk($sformatf("model r_ready[%0d] r%0d", p, v_ra[p]), 32'(bus.is_r_ready_o[p]),
          32'(m_it[v_ra[p]] == ct_v[v_ra[p]]));
    end
  endtask

  task automatic model_step();
    bit rdy;
    bit any;
    rdy = m_ready();
    any = 1'b0;
    if (v_rst) begin
      model_reset();
      return;
    end
    for (int l = 0; l < ISSUE_W; l++) begin
      if (v_iv[l] && rdy) begin
        any = 1'b1;
        if (v_wa[l] != 0) begin
          m_it[v_wa[l]] = m_seq * (1 << LANE_W) + l;
          m_infl++;
          pend.push_back('{a: int'(v_wa[l]), t: m_seq * (1 << LANE_W) + l});
        end
      end
    end
    for (int l = 0; l < ISSUE_W; l++) begin
      if (v_wbv[l] && v_wba[l] != 0) begin
        m_ct[v_wba[l]] = int'(v_wbt[l]);
        m_infl--;
      end
    end
    if (any) m_seq = (m_seq == (1 << SEQ_W) - 1) ? 1 : m_seq + 1;
    if (!m_drain) m_drain = v_fl;
    else if (!v_fl && m_infl == 0) m_drain = 1'b0;
  endtask

  // Apply inputs, let combinational outputs settle, compare against the model.
  task automatic eval();
    drive();
    #1;
    model_check();
  endtask

  task automatic adv();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_in();
    v_rst = 1'b1;
    drive();
    #1;
    model_step();
    @(negedge clk);
    v_rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] iv;  logic [4:0] wa0;  logic [4:0] wa1;
    logic [1:0] wbv; logic [4:0] wba0; logic [4:0] wba1;
    logic [3:0] wbt0; logic [3:0] wbt1;
    logic [3:0] e_wt0; logic [3:0] e_wt1; logic [3:0] e_rt0; logic [3:0] e_rt1;
    logic [3:0] e_rdy;
  } vec_t;

  function automatic vec_t mk(logic [1:0] iv, logic [4:0] wa0, logic [4:0] wa1,
                              logic [1:0] wbv, logic [4:0] wba0, logic [4:0] wba1,
                              logic [3:0] wbt0, logic [3:0] wbt1,
                              logic [3:0] e_wt0, logic [3:0] e_wt1,
                              logic [3:0] e_rt0, logic [3:0] e_rt1, logic [3:0] e_rdy);
    vec_t v;
    v.iv = iv; v.wa0 = wa0; v.wa1 = wa1; v.wbv = wbv; v.wba0 = wba0; v.wba1 = wba1;
    v.wbt0 = wbt0; v.wbt1 = wbt1; v.e_wt0 = e_wt0; v.e_wt1 = e_wt1;
    v.e_rt0 = e_rt0; v.e_rt1 = e_rt1; v.e_rdy = e_rdy;
    return v;
  endfunction

  vec_t vt [9];

  initial begin
    int idx;
    // Read ports fixed at r3, r7, r5, r0; tag = seq*2 + lane.
    vt[0] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 2, 3, 0, 0, 4'b1111);
    vt[1] = mk(2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 2, 3, 0, 0, 4'b1111);
    vt[2] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 4, 5, 2, 0, 4'b1110);
    vt[3] = mk(2'b00, 0, 0, 2'b01, 3, 0, 2, 0, 4, 5, 2, 0, {3'b111, BYP});
    vt[4] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 4, 5, 2, 0, 4'b1111);
    vt[5] = mk(2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 4, 5, 2, 0, 4'b1111);
    vt[6] = mk(2'b00, 0, 0, 2'b01, 7, 0, 4, 0, 6, 7, 2, 5, 4'b1101);
    vt[7] = mk(2'b00, 0, 0, 2'b10, 0, 7, 0, 5, 6, 7, 2, 5, {2'b11, BYP, 1'b1});
    vt[8] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 6, 7, 2, 5, 4'b1111);

    clear_in();
    drive();
    @(negedge clk);
    do_reset();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      clear_in();
      v_iv = vt[i].iv; v_wa[0] = vt[i].wa0; v_wa[1] = vt[i].wa1;
      v_wbv = vt[i].wbv; v_wba[0] = vt[i].wba0; v_wba[1] = vt[i].wba1;
      v_wbt[0] = vt[i].wbt0; v_wbt[1] = vt[i].wbt1;
      v_ra[0] = 5'd3; v_ra[1] = 5'd7; v_ra[2] = 5'd5; v_ra[3] = 5'd0;
      eval();
      chk($sformatf("vec%0d issue_ready", i), 32'(bus.issue_ready_o), 32'd1);
      chk($sformatf("vec%0d w_tag0", i), 32'(bus.is_w_tag_o[0]), 32'(vt[i].e_wt0));
      chk($sformatf("vec%0d w_tag1", i), 32'(bus.is_w_tag_o[1]), 32'(vt[i].e_wt1));
      chk($sformatf("vec%0d r_tag0", i), 32'(bus.is_r_tag_o[0]), 32'(vt[i].e_rt0));
      chk($sformatf("vec%0d r_tag1", i), 32'(bus.is_r_tag_o[1]), 32'(vt[i].e_rt1));
      chk($sformatf("vec%0d r_tag2", i), 32'(bus.is_r_tag_o[2]), 32'd0);
      chk($sformatf("vec%0d r_tag3", i), 32'(bus.is_r_tag_o[3]), 32'd0);
      chk($sformatf("vec%0d r_ready", i), 32'(bus.is_r_ready_o), 32'(vt[i].e_rdy));
      adv();
    end

    // Throttle at 5 in flight, then sequence wrap 7 -> 1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_in(); v_iv = 2'b01; v_wa[0] = 5'(i + 1);
      eval(); chk($sformatf("throttle ready@%0d", i), 32'(bus.issue_ready_o), 32'd1); adv();
    end
    clear_in(); v_iv = 2'b11; v_wa[0] = 5'd20; v_wa[1] = 5'd21;
    eval();
    chk("throttle ready@5", 32'(bus.issue_ready_o), 32'd0);
    chk("throttle w_tag0", 32'(bus.is_w_tag_o[0]), 32'd12);
    adv();
    clear_in(); v_ra[0] = 5'd20;
    eval();
    chk("blocked issue seq", 32'(bus.is_w_tag_o[0]), 32'd12);
    chk("blocked issue r20", 32'(bus.is_r_tag_o[0]), 32'd0);
    adv();
    for (int i = 0; i < 5; i++) begin
      clear_in(); v_wbv = 2'b01; v_wba[0] = 5'(i + 1); v_wbt[0] = 4'(2 * (i + 1));
      eval(); adv();
    end
    clear_in(); v_iv = 2'b01; v_wa[0] = 5'd6;
    eval(); chk("seq6 w_tag0", 32'(bus.is_w_tag_o[0]), 32'd12); adv();
    clear_in(); v_iv = 2'b01; v_wa[0] = 5'd8;
    eval(); chk("seq7 w_tag0", 32'(bus.is_w_tag_o[0]), 32'd14); adv();
    clear_in(); v_iv = 2'b01; v_wa[0] = 5'd9;
    eval(); chk("seq wrap w_tag0", 32'(bus.is_w_tag_o[0]), 32'd2); adv();

    // Flush with 3 in flight (r6:12, r8:14, r9:2)
    clear_in(); v_fl = 1'b1;
    eval(); chk("flush cycle ready", 32'(bus.issue_ready_o), 32'd1); adv();
    for (int i = 0; i < 2; i++) begin
      clear_in(); v_iv = 2'b11; v_wa[0] = 5'd10; v_wa[1] = 5'd11; v_ra[0] = 5'd10;
      eval();
      chk($sformatf("drain ready%0d", i), 32'(bus.issue_ready_o), 32'd0);
      chk($sformatf("drain seq%0d", i), 32'(bus.is_w_tag_o[0]), 32'd4);
      chk($sformatf("drain r10 tag%0d", i), 32'(bus.is_r_tag_o[0]), 32'd0);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      clear_in(); v_wbv = 2'b01;
      v_wba[0] = (i == 0) ? 5'd6 : (i == 1) ? 5'd8 : 5'd9;
      v_wbt[0] = (i == 0) ? 4'd12 : (i == 1) ? 4'd14 : 4'd2;
      eval(); chk($sformatf("drain wb%0d ready", i), 32'(bus.issue_ready_o), 32'd0); adv();
    end
    clear_in();
    eval(); chk("post drain ready", 32'(bus.issue_ready_o), 32'd1); adv();

    // Reset while draining with 2 in flight
    do_reset();
    clear_in(); v_iv = 2'b11; v_wa[0] = 5'd1; v_wa[1] = 5'd2;
    eval(); adv();
    clear_in(); v_fl = 1'b1;
    eval(); adv();
    clear_in();
    eval(); chk("pre-rst drain ready", 32'(bus.issue_ready_o), 32'd0); adv();
    clear_in(); v_rst = 1'b1;
    eval(); adv();
    clear_in(); v_ra[0] = 5'd1; v_ra[1] = 5'd2; v_ra[2] = 5'd5;
    eval();
    chk("rst ready", 32'(bus.issue_ready_o), 32'd1);
    chk("rst w_tag0", 32'(bus.is_w_tag_o[0]), 32'd2);
    chk("rst w_tag1", 32'(bus.is_w_tag_o[1]), 32'd3);
    chk("rst r1 tag", 32'(bus.is_r_tag_o[0]), 32'd0);
    chk("rst r2 tag", 32'(bus.is_r_tag_o[1]), 32'd0);
    chk("rst r_ready", 32'(bus.is_r_ready_o), 32'hf);
    adv();

    // Randomized phase
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clear_in();
      v_rst = ($urandom_range(0, 299) == 0);
      v_fl  = ($urandom_range(0, 39) == 0);
      for (int l = 0; l < ISSUE_W; l++) begin
        v_iv[l] = 1'($urandom_range(0, 1));
        v_wa[l] = 5'($urandom_range(0, 31));
      end
      for (int p = 0; p < RP; p++) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1)
          v_ra[p] = 5'(pend[$urandom_range(0, pend.size() - 1)].a);
        else
          v_ra[p] = 5'($urandom_range(0, 31));
      end
      for (int l = 0; l < ISSUE_W; l++) begin
        if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx = $urandom_range(0, pend.size() - 1);
          v_wbv[l] = 1'b1;
          v_wba[l] = 5'(pend[idx].a);
          v_wbt[l] = TAG_W'(pend[idx].t);
          pend.delete(idx);
        end
      end
      eval();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
